// File: rtl/mau_pkg.sv
// mau_pkg: shared definitions for the memory access unit.
//   MNONE/MREAD/MWRITE - mem_cmd encodings
//   mau_state_t        - control FSM states
package mau_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [2:0] {
        ST_RST,
        ST_FETCH,
        ST_EXEC,
        ST_DATA,
        ST_DRESP,
        ST_HALT
    } mau_state_t;

endpackage

// File: rtl/mau_if.sv
// mau_if: memory-side bus of the memory access unit.
//   mem_cmd   - 00 NONE, 01 READ, 10 WRITE (driven by the unit)
//   mem_addr  - access address              (driven by the unit)
//   mem_wdata - store data                  (driven by the unit)
//   mem_rdata - load/fetch data             (driven by memory)
//   mem_ready - access completes this cycle (driven by memory)
interface mau_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 9
);
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_cmd,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_cmd,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mau_ld_reg.sv
// mau_ld_reg: W-bit register with load enable and synchronous reset.
//   clk, reset - clock, synchronous active-high reset (loads RST_VAL)
//   en         - load d on the rising edge
//   d, q       - data in / registered data out
module mau_ld_reg #(
    parameter int unsigned   W       = 8,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: fetches instructions into an instruction register and
// performs single data loads/stores on behalf of the core, sharing one
// memory port.
//   clk, reset          - clock, synchronous active-high reset
//   instr, instr_valid  - instruction register, valid while executing
//   instr_ack, br_en,
//   br_target           - core done with instruction / optional branch
//   dreq_*              - data request (we, addr, wdata)
//   dresp_valid,
//   dresp_data          - one-cycle completion pulse / last load data
//   halt_req, halted    - enter / report the terminal HALT state
//   bus_err             - memory wait timeout (sticky until reset)
//   pc                  - current program counter
//   mem                 - memory bus (mau_if master)
// Optional feature: define MAU_TIMEOUT_EN to bound memory waits to
// TIMEOUT_CYC cycles; otherwise bus_err is 0 and waits are unbounded.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       ADDR_W      = 9,
    parameter logic [ADDR_W-1:0] RST_VEC     = '0,
    parameter int unsigned       TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ack,
    input  logic              br_en,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              dreq_valid,
    input  logic              dreq_we,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic [DATA_W-1:0] dreq_wdata,
    output logic              dresp_valid,
    output logic [DATA_W-1:0] dresp_data,
    input  logic              halt_req,
    output logic              halted,
    output logic              bus_err,
    output logic [ADDR_W-1:0] pc,
    mau_if.master             mem
);

    mau_state_t        state_q, state_d;

    logic              pc_en;
    logic [ADDR_W-1:0] pc_d;
    logic              ir_en;
    logic              req_en;
    logic              dresp_en;
    logic              we_q;
    logic [ADDR_W-1:0] daddr_q;
    logic [DATA_W-1:0] dwdata_q;

    // wait_cyc: in FETCH/DATA with memory not ready this cycle.
    // tmo_hit : this wait cycle is the last one allowed.
    logic              wait_cyc;
    logic              tmo_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_en         = 1'b0;
        pc_d          = pc + ADDR_W'(1);
        ir_en         = 1'b0;
        req_en        = 1'b0;
        dresp_en      = 1'b0;
        wait_cyc      = 1'b0;
        mem.mem_cmd   = MNONE;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;

        case (state_q)
            ST_RST: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem.mem_cmd  = MREAD;
                mem.mem_addr = pc;
                if (mem.mem_ready) begin
                    ir_en   = 1'b1;
                    pc_en   = 1'b1;
                    state_d = ST_EXEC;
                end else begin
                    wait_cyc = 1'b1;
                    if (tmo_hit) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_EXEC: begin
                // A data request pre-empts a same-cycle ack/branch; the
                // core re-issues the ack once the access completes.
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (dreq_valid) begin
                    req_en  = 1'b1;
                    state_d = ST_DATA;
                end else if (instr_ack) begin
                    if (br_en) begin
                        pc_en = 1'b1;
                        pc_d  = br_target;
                    end
                    state_d = ST_FETCH;
                end
            end
            ST_DATA: begin
                mem.mem_cmd   = we_q ? MWRITE : MREAD;
                mem.mem_addr  = daddr_q;
                mem.mem_wdata = dwdata_q;
                if (mem.mem_ready) begin
                    dresp_en = ~we_q;
                    state_d  = ST_DRESP;
                end else begin
                    wait_cyc = 1'b1;
                    if (tmo_hit) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_DRESP: begin
                state_d = ST_EXEC;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    assign instr_valid = (state_q == ST_EXEC);
    assign dresp_valid = (state_q == ST_DRESP);
    assign halted      = (state_q == ST_HALT);

    mau_ld_reg #(.W(ADDR_W), .RST_VAL(RST_VEC)) u_pc_reg (
        .clk(clk), .reset(reset), .en(pc_en), .d(pc_d), .q(pc)
    );

    mau_ld_reg #(.W(DATA_W), .RST_VAL('0)) u_ir_reg (
        .clk(clk), .reset(reset), .en(ir_en), .d(mem.mem_rdata), .q(instr)
    );

    mau_ld_reg #(.W(1), .RST_VAL('0)) u_we_reg (
        .clk(clk), .reset(reset), .en(req_en), .d(dreq_we), .q(we_q)
    );

    mau_ld_reg #(.W(ADDR_W), .RST_VAL('0)) u_daddr_reg (
        .clk(clk), .reset(reset), .en(req_en), .d(dreq_addr), .q(daddr_q)
    );

    mau_ld_reg #(.W(DATA_W), .RST_VAL('0)) u_dwdata_reg (
        .clk(clk), .reset(reset), .en(req_en), .d(dreq_wdata), .q(dwdata_q)
    );

    mau_ld_reg #(.W(DATA_W), .RST_VAL('0)) u_dresp_reg (
        .clk(clk), .reset(reset), .en(dresp_en), .d(mem.mem_rdata), .q(dresp_data)
    );

`ifdef MAU_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_cnt;

    // Counts consecutive not-ready wait cycles; any other cycle clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (wait_cyc) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err <= 1'b0;
        end else if (wait_cyc && tmo_hit) begin
            bus_err <= 1'b1;
        end
    end
`else
    logic tmo_unused;

    assign tmo_hit    = 1'b0;
    assign bus_err    = 1'b0;
    assign tmo_unused = wait_cyc ^ (|TIMEOUT_CYC);
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import mau_pkg::*;

    localparam int unsigned       DW  = 16;
    localparam int unsigned       AW  = 9;
    localparam logic [AW-1:0]     RV  = 9'h000;
    localparam int unsigned       TMO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          instr_ack;
    logic          br_en;
    logic [AW-1:0] br_target;
    logic          dreq_valid;
    logic          dreq_we;
    logic [AW-1:0] dreq_addr;
    logic [DW-1:0] dreq_wdata;
    logic          dresp_valid;
    logic [DW-1:0] dresp_data;
    logic          halt_req;
    logic          halted;
    logic          bus_err;
    logic [AW-1:0] pc;

    mau_if #(.DATA_W(DW), .ADDR_W(AW)) mem_bus ();

    mem_access_unit #(
        .DATA_W(DW), .ADDR_W(AW), .RST_VEC(RV), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .instr(instr), .instr_valid(instr_valid), .instr_ack(instr_ack),
        .br_en(br_en), .br_target(br_target),
        .dreq_valid(dreq_valid), .dreq_we(dreq_we), .dreq_addr(dreq_addr),
        .dreq_wdata(dreq_wdata), .dresp_valid(dresp_valid), .dresp_data(dresp_data),
        .halt_req(halt_req), .halted(halted), .bus_err(bus_err), .pc(pc),
        .mem(mem_bus.master)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: memory image plus architectural state.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_ir;
    logic [DW-1:0] m_dresp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        instr_ack         = 1'b0;
        br_en             = 1'b0;
        br_target         = '0;
        dreq_valid        = 1'b0;
        dreq_we           = 1'b0;
        dreq_addr         = '0;
        dreq_wdata        = '0;
        halt_req          = 1'b0;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = DW'($urandom);
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        mem_bus.mem_ready = 1'($urandom);
        tick();
        chk("rst_cmd", mem_bus.mem_cmd, MNONE);
        chk("rst_pc", pc, RV);
        chk("rst_instr", instr, 0);
        chk("rst_ivalid", instr_valid, 0);
        chk("rst_dvalid", dresp_valid, 0);
        chk("rst_ddata", dresp_data, 0);
        chk("rst_halted", halted, 0);
        chk("rst_buserr", bus_err, 0);
        chk("rst_addr", mem_bus.mem_addr, 0);
        reset = 1'b0;
        mem_bus.mem_ready = 1'b0;
        m_pc = RV;
        m_ir = '0;
        m_dresp = '0;
        tick();
    endtask

    // Precondition: unit is fetching. Completes after 'waits' stall cycles.
    task automatic fetch(input int waits);
        for (int i = 0; i <= waits; i++) begin
            chk("fetch_cmd", mem_bus.mem_cmd, MREAD);
            chk("fetch_addr", mem_bus.mem_addr, m_pc);
            chk("fetch_ivalid", instr_valid, 0);
            mem_bus.mem_ready = (i == waits);
            mem_bus.mem_rdata = (i == waits) ? mem[m_pc] : DW'($urandom);
            tick();
        end
        mem_bus.mem_ready = 1'b0;
        m_ir = mem[m_pc];
        m_pc = m_pc + AW'(1);
        chk("exec_ivalid", instr_valid, 1);
        chk("exec_instr", instr, m_ir);
        chk("exec_pc", pc, m_pc);
        chk("exec_cmd", mem_bus.mem_cmd, MNONE);
    endtask

    task automatic exec_idle(input int n);
        for (int i = 0; i < n; i++) begin
            mem_bus.mem_ready = 1'($urandom);
            mem_bus.mem_rdata = DW'($urandom);
            tick();
            chk("idle_ivalid", instr_valid, 1);
            chk("idle_instr", instr, m_ir);
            chk("idle_pc", pc, m_pc);
            chk("idle_cmd", mem_bus.mem_cmd, MNONE);
        end
        mem_bus.mem_ready = 1'b0;
    endtask

    task automatic ack(input logic br, input logic [AW-1:0] tgt);
        instr_ack = 1'b1;
        br_en     = br;
        br_target = tgt;
        tick();
        idle_inputs();
        if (br) m_pc = tgt;
        chk("ack_ivalid", instr_valid, 0);
        chk("ack_cmd", mem_bus.mem_cmd, MREAD);
        chk("ack_addr", mem_bus.mem_addr, m_pc);
        chk("ack_pc", pc, m_pc);
    endtask

    task automatic data(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int waits, input logic with_ack);
        dreq_valid = 1'b1;
        dreq_we    = we;
        dreq_addr  = a;
        dreq_wdata = wd;
        if (with_ack) begin
            instr_ack = 1'b1;
            br_en     = 1'b1;
            br_target = AW'($urandom);
        end
        tick();
        idle_inputs();
        for (int i = 0; i <= waits; i++) begin
            chk("data_cmd", mem_bus.mem_cmd, we ? MWRITE : MREAD);
            chk("data_addr", mem_bus.mem_addr, a);
            if (we) chk("data_wdata", mem_bus.mem_wdata, wd);
            chk("data_dvalid", dresp_valid, 0);
            chk("data_pc", pc, m_pc);
            mem_bus.mem_ready = (i == waits);
            mem_bus.mem_rdata = (i == waits && !we) ? mem[a] : DW'($urandom);
            tick();
        end
        mem_bus.mem_ready = 1'b0;
        if (we) mem[a] = wd;
        else    m_dresp = mem[a];
        chk("dresp_valid", dresp_valid, 1);
        chk("dresp_data", dresp_data, m_dresp);
        chk("dresp_cmd", mem_bus.mem_cmd, MNONE);
        chk("dresp_ivalid", instr_valid, 0);
        chk("dresp_instr", instr, m_ir);
        tick();
        chk("post_dvalid", dresp_valid, 0);
        chk("post_ivalid", instr_valid, 1);
        chk("post_ddata", dresp_data, m_dresp);
        chk("post_pc", pc, m_pc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        mem[0]       = 16'hD105;
        mem[9'h020]  = 16'h00AB;
        idle_inputs();

        // Reset and first fetch from word 0.
        do_reset();
        fetch(0);
        chk("first_instr", instr, 16'hD105);
        chk("first_pc", pc, 9'h001);

        // Load with three wait states.
        data(1'b0, 9'h020, '0, 3, 1'b0);
        chk("load_value", dresp_data, 16'h00AB);

        // Branch, then wrap of pc at the top of memory.
        ack(1'b1, 9'h1F0);
        fetch(1);
        ack(1'b1, 9'h1FF);
        fetch(2);
        chk("pc_wrap", pc, 9'h000);

        // Store that collides with an ack+branch: ack is dropped.
        data(1'b1, 9'h005, 16'h1234, 1, 1'b1);
        exec_idle(2);

        // Randomized traffic.
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 3))
                0: exec_idle(int'($urandom_range(1, 3)));
                1: begin
                    ack(1'($urandom), AW'($urandom));
                    fetch(int'($urandom_range(0, 3)));
                end
                default: data(1'($urandom), AW'($urandom), DW'($urandom),
                              int'($urandom_range(0, 3)), 1'($urandom));
            endcase
        end

        // Halt outranks a simultaneous data request and ack.
        halt_req   = 1'b1;
        dreq_valid = 1'b1;
        instr_ack  = 1'b1;
        br_en      = 1'b1;
        br_target  = AW'($urandom);
        tick();
        idle_inputs();
        chk("halt_halted", halted, 1);
        chk("halt_cmd", mem_bus.mem_cmd, MNONE);
        chk("halt_ivalid", instr_valid, 0);
        for (int i = 0; i < 5; i++) begin
            dreq_valid        = 1'($urandom);
            instr_ack         = 1'($urandom);
            br_en             = 1'b1;
            br_target         = AW'($urandom);
            mem_bus.mem_ready = 1'($urandom);
            tick();
            chk("halt_stay", halted, 1);
            chk("halt_pc", pc, m_pc);
            chk("halt_cmdh", mem_bus.mem_cmd, MNONE);
        end

        // Reset in the middle of a data wait abandons the access.
        do_reset();
        fetch(0);
        dreq_valid = 1'b1;
        dreq_we    = 1'b0;
        dreq_addr  = AW'($urandom);
        tick();
        idle_inputs();
        chk("mid_cmd0", mem_bus.mem_cmd, MREAD);
        tick();
        chk("mid_cmd1", mem_bus.mem_cmd, MREAD);
        reset = 1'b1;
        tick();
        chk("mid_rst_cmd", mem_bus.mem_cmd, MNONE);
        chk("mid_rst_pc", pc, RV);
        chk("mid_rst_dvalid", dresp_valid, 0);
        chk("mid_rst_ddata", dresp_data, 0);
        reset = 1'b0;
        m_pc = RV;
        m_ir = '0;
        m_dresp = '0;
        tick();
        chk("restart_cmd", mem_bus.mem_cmd, MREAD);
        chk("restart_addr", mem_bus.mem_addr, RV);

`ifdef MAU_TIMEOUT_EN
        for (int i = 1; i <= int'(TMO); i++) begin
            chk("tmo_wait_halted", halted, 0);
            chk("tmo_wait_cmd", mem_bus.mem_cmd, MREAD);
            chk("tmo_wait_err", bus_err, 0);
            tick();
        end
        chk("tmo_halted", halted, 1);
        chk("tmo_buserr", bus_err, 1);
        chk("tmo_cmd", mem_bus.mem_cmd, MNONE);
        for (int i = 0; i < 3; i++) begin
            mem_bus.mem_ready = 1'($urandom);
            instr_ack = 1'($urandom);
            tick();
            chk("tmo_hold_err", bus_err, 1);
            chk("tmo_hold_halted", halted, 1);
            chk("tmo_hold_pc", pc, RV);
        end
        do_reset();
`else
        for (int i = 0; i < 300; i++) begin
            if (i % 60 == 0) begin
                chk("nowait_cmd", mem_bus.mem_cmd, MREAD);
                chk("nowait_err", bus_err, 0);
                chk("nowait_halted", halted, 0);
            end
            tick();
        end
        fetch(0);
        chk("nowait_err_end", bus_err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
